rv32_mc_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32I core: walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Gates the combinational control decoder's write and PC strobes so they fire only in the correct state.
- Drives request/grant/rvalid handshakes to the instruction and data memories.
- Detects illegal opcodes and bus timeouts, and keeps cycle and retired-instruction counters.

---
 rtl/rv32_mc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rv32_mc_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mc_sequencer.sv
// Multi-cycle FETCH/FWAIT/DECODE/EXEC/MEM/MWAIT/WB sequencer for an RV32I core.
// Gates decoder strobes by state, drives imem/dmem handshakes, traps on illegal opcodes and bus timeouts.
module rv32_mc_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic [31:0]      instruction,
   input  logic             imem_rdata_valid,
   input  logic             imem_gnt,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic             pcsel_i,
   input  logic             regwen_i,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel_o,
   output logic             reg_we,
   output logic             busy,
   output logic             halted,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t           state;
   logic             is_mem;
   logic             is_store;
   logic [CNT_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] tmo_next;
   logic             tmo_hit;
   logic [6:0]       opcode;
   logic             op_legal;
   logic             op_load;
   logic             op_store;
   logic             unused_ir_bits;

   assign opcode         = instruction[6:0];
   assign op_load        = (opcode == OP_LOAD);
   assign op_store       = (opcode == OP_STORE);
   assign unused_ir_bits = ^instruction[31:7];

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_IMM, OP_REG: op_legal = 1'b1;
         default:                           op_legal = 1'b0;
      endcase
   end

   // The count includes the current waiting cycle, so the trap fires on the MEM_TIMEOUT-th idle cycle.
   assign tmo_next = tmo_cnt + CNT_W'(1);
   assign tmo_hit  = (tmo_next == TMO_LIMIT);

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         is_mem      <= 1'b0;
         is_store    <= 1'b0;
         tmo_cnt     <= '0;
         trap_cause  <= 2'b00;
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
         case (state)
            S_FETCH: begin
               if (run_i) begin
                  if (imem_gnt) begin
                     state   <= S_FWAIT;
                     tmo_cnt <= '0;
                  end else if (tmo_hit) begin
                     state      <= S_TRAP;
                     trap_cause <= 2'b10;
                  end else begin
                     tmo_cnt <= tmo_next;
                  end
               end
            end
            S_FWAIT: begin
               if (imem_rdata_valid) begin
                  state <= S_DECODE;
               end else if (tmo_hit) begin
                  state      <= S_TRAP;
                  trap_cause <= 2'b10;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            S_DECODE: begin
               if (op_legal) begin
                  state    <= S_EXEC;
                  is_mem   <= op_load | op_store;
                  is_store <= op_store;
               end else begin
                  state      <= S_TRAP;
                  trap_cause <= 2'b01;
               end
            end
            S_EXEC: begin
               if (is_mem) begin
                  state   <= S_MEM;
                  tmo_cnt <= '0;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_gnt) begin
                  if (is_store) begin
                     state <= S_WB;
                  end else begin
                     state   <= S_MWAIT;
                     tmo_cnt <= '0;
                  end
               end else if (tmo_hit) begin
                  state      <= S_TRAP;
                  trap_cause <= 2'b11;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            S_MWAIT: begin
               if (dmem_rvalid) begin
                  state <= S_WB;
               end else if (tmo_hit) begin
                  state      <= S_TRAP;
                  trap_cause <= 2'b11;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            S_WB: begin
               instret_cnt <= instret_cnt + CNT_W'(1);
               state       <= S_FETCH;
               tmo_cnt     <= '0;
            end
            S_TRAP:  state <= S_TRAP;
            default: state <= S_TRAP;
         endcase
      end
   end

   // The fetch request and IR load must act in the same cycle as run_i / rvalid; rst drops the request at once.
   assign imem_req = (state == S_FETCH) & run_i & ~rst;
   assign ir_we    = (state == S_FWAIT) & imem_rdata_valid;
   assign dmem_req = (state == S_MEM);
   assign dmem_we  = (state == S_MEM) & is_store;
   assign pc_we    = (state == S_WB);
   assign pc_sel_o = (state == S_WB) & pcsel_i;
   assign reg_we   = (state == S_WB) & regwen_i;
   assign halted   = (state == S_TRAP);
   assign busy     = ~rst & (state != S_TRAP) & ~((state == S_FETCH) & ~run_i);

endmodule

// File: tb/tb_rv32_mc_sequencer.sv
// Directed bench for rv32_mc_sequencer: opcode table with a responsive memory, then
// hand-written sequences for delayed handshakes, run_i stop, illegal opcode, and timeouts.
module tb_rv32_mc_sequencer;

   localparam int CNT_W = 32;

   logic             clk;
   logic             rst;
   logic             run_i;
   logic [31:0]      instruction;
   logic             imem_rdata_valid;
   logic             imem_gnt;
   logic             dmem_gnt;
   logic             dmem_rvalid;
   logic             pcsel_i;
   logic             regwen_i;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic             ir_we;
   logic             pc_we;
   logic             pc_sel_o;
   logic             reg_we;
   logic             busy;
   logic             halted;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   logic [31:0] imem_word;
   logic [31:0] ir_q;
   int          checks;
   int          errors;

   rv32_mc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .run_i            (run_i),
      .instruction      (instruction),
      .imem_rdata_valid (imem_rdata_valid),
      .imem_gnt         (imem_gnt),
      .dmem_gnt         (dmem_gnt),
      .dmem_rvalid      (dmem_rvalid),
      .pcsel_i          (pcsel_i),
      .regwen_i         (regwen_i),
      .imem_req         (imem_req),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .ir_we            (ir_we),
      .pc_we            (pc_we),
      .pc_sel_o         (pc_sel_o),
      .reg_we           (reg_we),
      .busy             (busy),
      .halted           (halted),
      .trap_cause       (trap_cause),
      .cycle_cnt        (cycle_cnt),
      .instret_cnt      (instret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction register outside the sequencer, loaded by ir_we.
   always @(posedge clk or posedge rst) begin
      if (rst) ir_q <= 32'h0;
      else if (ir_we) ir_q <= imem_word;
   end
   assign instruction = ir_q;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      string       name;
      logic [31:0] word;
      logic        pcsel;
      logic        regwen;
      int          len;
      int          kind;   // 0 no memory access, 1 load, 2 store
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ig, input logic iv, input logic dg, input logic dv);
      run_i            = r;
      imem_gnt         = ig;
      imem_rdata_valid = iv;
      dmem_gnt         = dg;
      dmem_rvalid      = dv;
   endtask

   task automatic cyc(input logic r, input logic ig, input logic iv, input logic dg, input logic dv);
      @(negedge clk);
      drive(r, ig, iv, dg, dv);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // One instruction against an always-ready memory; stops at the WB cycle.
   task automatic run_instr(output int len, output int nreg, output int psel, output int nir,
                            output int ndreq, output int ndwe, output bit done);
      len = 0; nreg = 0; psel = 0; nir = 0; ndreq = 0; ndwe = 0; done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
         len++;
         if (reg_we)   nreg++;
         if (ir_we)    nir++;
         if (dmem_req) ndreq++;
         if (dmem_we)  ndwe++;
         if (pc_we) begin
            psel = int'(pc_sel_o);
            done = 1'b1;
         end
      end
   endtask

   initial begin
      int len, nreg, psel, nir, ndreq, ndwe;
      bit done;
      int exp_cyc;
      int exp_ret;

      checks    = 0;
      errors    = 0;
      imem_word = 32'h0;
      pcsel_i   = 1'b0;
      regwen_i  = 1'b0;
      rst       = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      vecs[0] = '{"addi",  32'h00500093, 1'b0, 1'b1, 5, 0};
      vecs[1] = '{"lui",   32'h123450B7, 1'b0, 1'b1, 5, 0};
      vecs[2] = '{"auipc", 32'h00001117, 1'b0, 1'b1, 5, 0};
      vecs[3] = '{"jal",   32'h008000EF, 1'b1, 1'b1, 5, 0};
      vecs[4] = '{"jalr",  32'h000080E7, 1'b1, 1'b1, 5, 0};
      vecs[5] = '{"beq",   32'h00208463, 1'b1, 1'b0, 5, 0};
      vecs[6] = '{"add",   32'h002081B3, 1'b0, 1'b1, 5, 0};
      vecs[7] = '{"lw",    32'h0000A103, 1'b0, 1'b1, 7, 1};
      vecs[8] = '{"sw",    32'h0020A023, 1'b0, 1'b0, 6, 2};

      // Reset with every input active: outputs must all read zero.
      #1;
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      pcsel_i  = 1'b1;
      regwen_i = 1'b1;
      #3;
      check("rst imem_req", imem_req, 0);
      check("rst busy", busy, 0);
      check("rst halted", halted, 0);
      check("rst trap_cause", trap_cause, 0);
      check("rst cycle_cnt", cycle_cnt, 0);
      check("rst instret_cnt", instret_cnt, 0);
      check("rst pc_we", pc_we, 0);
      check("rst reg_we", reg_we, 0);
      check("rst pc_sel_o", pc_sel_o, 0);
      check("rst ir_we", ir_we, 0);
      check("rst dmem_req", dmem_req, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Opcode table, back to back, with an always-ready memory.
      exp_cyc = 0;
      exp_ret = 0;
      for (int i = 0; i < 9; i++) begin
         imem_word = vecs[i].word;
         pcsel_i   = vecs[i].pcsel;
         regwen_i  = vecs[i].regwen;
         run_instr(len, nreg, psel, nir, ndreq, ndwe, done);
         check($sformatf("%s reached wb", vecs[i].name), 32'(done), 1);
         check($sformatf("%s cycles", vecs[i].name), len, vecs[i].len);
         check($sformatf("%s reg_we pulses", vecs[i].name), nreg, 32'(vecs[i].regwen));
         check($sformatf("%s pc_sel_o", vecs[i].name), psel, 32'(vecs[i].pcsel));
         check($sformatf("%s ir_we pulses", vecs[i].name), nir, 1);
         check($sformatf("%s dmem_req cycles", vecs[i].name), ndreq, (vecs[i].kind != 0) ? 1 : 0);
         check($sformatf("%s dmem_we cycles", vecs[i].name), ndwe, (vecs[i].kind == 2) ? 1 : 0);
         exp_cyc += vecs[i].len;
         exp_ret += 1;
         @(posedge clk);
         #1;
         check($sformatf("%s cycle_cnt", vecs[i].name), cycle_cnt, exp_cyc);
         check($sformatf("%s instret_cnt", vecs[i].name), instret_cnt, exp_ret);
      end

      // LW: grant on the 3rd MEM cycle, rvalid 3 cycles after the grant.
      do_reset();
      imem_word = 32'h0000A103;
      pcsel_i   = 1'b0;
      regwen_i  = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lw fetch imem_req", imem_req, 1);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("lw fwait ir_we", ir_we, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lw exec dmem_req", dmem_req, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, 1'b0, (k == 2), 1'b0);
         check($sformatf("lw mem%0d dmem_req", k), dmem_req, 1);
         check($sformatf("lw mem%0d dmem_we", k), dmem_we, 0);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, (k == 2));
         check($sformatf("lw mwait%0d dmem_req", k), dmem_req, 0);
         check($sformatf("lw mwait%0d reg_we", k), reg_we, 0);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lw wb reg_we", reg_we, 1);
      check("lw wb pc_we", pc_we, 1);
      @(posedge clk);
      #1;
      check("lw instret_cnt", instret_cnt, 1);
      check("lw cycle_cnt", cycle_cnt, 11);

      // SW: grant on the 4th MEM cycle, exactly at the timeout boundary.
      do_reset();
      imem_word = 32'h0020A023;
      regwen_i  = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b0, 1'b0, (k == 3), 1'b0);
         check($sformatf("sw mem%0d dmem_req", k), dmem_req, 1);
         check($sformatf("sw mem%0d dmem_we", k), dmem_we, 1);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("sw wb pc_we", pc_we, 1);
      check("sw wb reg_we", reg_we, 0);
      check("sw wb dmem_req", dmem_req, 0);
      @(posedge clk);
      #1;
      check("sw halted", halted, 0);
      check("sw instret_cnt", instret_cnt, 1);
      check("sw cycle_cnt", cycle_cnt, 9);

      // BEQ taken, run_i dropped in EXEC: completes, then idles in FETCH.
      do_reset();
      imem_word = 32'h00208463;
      pcsel_i   = 1'b1;
      regwen_i  = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("beq exec busy", busy, 1);
      check("beq exec pc_sel_o", pc_sel_o, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("beq wb pc_we", pc_we, 1);
      check("beq wb pc_sel_o", pc_sel_o, 1);
      check("beq wb reg_we", reg_we, 0);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         check($sformatf("beq idle%0d imem_req", k), imem_req, 0);
         check($sformatf("beq idle%0d busy", k), busy, 0);
         check($sformatf("beq idle%0d pc_we", k), pc_we, 0);
      end
      @(posedge clk);
      #1;
      check("beq cycle_cnt", cycle_cnt, 7);
      check("beq instret_cnt", instret_cnt, 1);

      // FENCE is illegal: TRAP after DECODE, counters freeze, async reset clears.
      do_reset();
      imem_word = 32'h0000000F;
      pcsel_i   = 1'b0;
      regwen_i  = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("fence decode halted", halted, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
         check($sformatf("fence trap%0d halted", k), halted, 1);
         check($sformatf("fence trap%0d trap_cause", k), trap_cause, 2'b01);
         check($sformatf("fence trap%0d busy", k), busy, 0);
         check($sformatf("fence trap%0d imem_req", k), imem_req, 0);
         check($sformatf("fence trap%0d ir_we", k), ir_we, 0);
      end
      check("fence cycle_cnt frozen", cycle_cnt, 3);
      check("fence instret_cnt", instret_cnt, 0);
      #2;
      rst = 1'b1;
      #1;
      check("fence rst halted", halted, 0);
      check("fence rst trap_cause", trap_cause, 0);
      check("fence rst cycle_cnt", cycle_cnt, 0);
      check("fence rst imem_req", imem_req, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // imem timeout: no rvalid for 4 FWAIT cycles.
      do_reset();
      imem_word = 32'h00500093;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("itmo fwait%0d halted", k), halted, 0);
      end
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("itmo halted", halted, 1);
      check("itmo trap_cause", trap_cause, 2'b10);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("itmo cycle_cnt frozen", cycle_cnt, 5);

      // Same, with rvalid on the 4th FWAIT cycle: handshake wins.
      do_reset();
      regwen_i = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, (k == 3), 1'b0, 1'b0);
      check("iboundary ir_we", ir_we, 1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("iboundary decode halted", halted, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("iboundary wb reg_we", reg_we, 1);
      @(posedge clk);
      #1;
      check("iboundary instret_cnt", instret_cnt, 1);

      // dmem timeout: load never granted.
      do_reset();
      imem_word = 32'h0000A103;
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("dtmo halted", halted, 1);
      check("dtmo trap_cause", trap_cause, 2'b11);
      check("dtmo dmem_req", dmem_req, 0);

      // Idling with run_i=0 never times out; ungranted fetch with run_i=1 does.
      do_reset();
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ftmo idle halted", halted, 0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ftmo halted", halted, 1);
      check("ftmo trap_cause", trap_cause, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
